// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: state encoding, frame width,
// default sclk divider and the per-frame transmit pattern selection.
package spi_pkg;

  localparam int FRAME_W     = 8;
  localparam int CLK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    STORE,
    DONE
  } spi_state_t;

  // all_1s wins over all_0s; otherwise the memory word goes out untouched
  function automatic logic [FRAME_W-1:0] frame_pattern(
    input logic               all_1s,
    input logic               all_0s,
    input logic [FRAME_W-1:0] data
  );
    logic [FRAME_W-1:0] val;
    val = data;
    if (all_1s)      val = '1;
    else if (all_0s) val = '0;
    return val;
  endfunction

endpackage

// File: rtl/spi_master_fsm_if.sv
// SPI bus bundle: the master drives sclk/mosi/cs_n and samples miso.
interface spi_master_fsm_if;

  logic sclk;
  logic mosi;
  logic miso;
  logic cs_n;

  modport master (output sclk, output mosi, output cs_n, input miso);
  modport slave  (input sclk, input mosi, input cs_n, output miso);

endinterface

// File: rtl/spi_clk_div.sv
// sclk generator: toggles sclk every CLK_DIV clk cycles while enabled and
// flags the clk edge on which sclk rises or falls; parks sclk low when idle.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  // strobes coincide with the clk edge that actually moves sclk
  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_fsm.sv
// Mode-0 SPI master that streams words 0..n_tx_end from TX memory and writes
// each received byte to RX memory at the same index.
module spi_master_fsm
  import spi_pkg::*;
#(
  parameter int N       = 5,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               send,
  input  logic               cs_ctrl,
  input  logic               all_1s,
  input  logic               all_0s,
  input  logic [N:0]         n_tx_end,
  input  logic [FRAME_W-1:0] tx_data,
  output logic [N:0]         tx_addr,
  output logic               rx_we,
  output logic [N:0]         rx_addr,
  output logic [FRAME_W-1:0] rx_data,
  output logic [N+1:0]       n_rx_cnt,
  output logic               send_clr,
  output logic               busy,
  spi_master_fsm_if.master   bus
);

  localparam int BW = $clog2(FRAME_W);

  spi_state_t         state;
  logic               send_q;
  logic               send_rise;
  logic [N:0]         end_q;
  logic [N:0]         idx;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] load_val;
  logic [BW-1:0]      bit_cnt;
  logic               mosi_r;
  logic               shift_en;
  logic               sclk_w;
  logic               rise;
  logic               fall;

  assign send_rise = send && !send_q;
  assign shift_en  = (state == SHIFT);
  assign load_val  = frame_pattern(all_1s, all_0s, tx_data);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .sclk (sclk_w),
    .rise (rise),
    .fall (fall)
  );

  assign bus.sclk = sclk_w;
  assign bus.mosi = mosi_r;
  assign bus.cs_n = ~((state != IDLE) || cs_ctrl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      send_q   <= 1'b0;
      end_q    <= '0;
      idx      <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      mosi_r   <= 1'b0;
      tx_addr  <= '0;
      rx_we    <= 1'b0;
      rx_addr  <= '0;
      rx_data  <= '0;
      n_rx_cnt <= '0;
      send_clr <= 1'b0;
      busy     <= 1'b0;
    end else begin
      send_q   <= send;
      rx_we    <= 1'b0;
      send_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (send_rise) begin
            state    <= FETCH;
            end_q    <= n_tx_end;
            idx      <= '0;
            n_rx_cnt <= '0;
            tx_addr  <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          // first bit goes out on SHIFT entry, before any sclk activity
          shreg   <= load_val;
          mosi_r  <= load_val[FRAME_W-1];
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (rise) shreg <= {shreg[FRAME_W-2:0], bus.miso};
          if (fall) begin
            if (bit_cnt == BW'(FRAME_W - 1)) begin
              state    <= STORE;
              rx_we    <= 1'b1;
              rx_addr  <= idx;
              rx_data  <= shreg;
              n_rx_cnt <= n_rx_cnt + (N+2)'(1);
            end else begin
              bit_cnt  <= bit_cnt + BW'(1);
              mosi_r   <= shreg[FRAME_W-1];
            end
          end
        end
        STORE: begin
          if (idx == end_q) begin
            state    <= DONE;
            send_clr <= 1'b1;
          end else begin
            idx      <= idx + (N+1)'(1);
            tx_addr  <= tx_addr + (N+1)'(1);
            state    <= FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fsm.sv
// Randomised and directed bench for spi_master_fsm with miso looped to mosi;
// expected bytes are queued on issue and retired by a separate bus monitor.
module tb_spi_master_fsm;
  import spi_pkg::*;

  localparam int N         = 5;
  localparam int AW        = N + 1;
  localparam int CD        = 2;
  localparam int FRAME_CYC = 16 * CD + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           send = 1'b0;
  logic           cs_ctrl = 1'b0;
  logic           all_1s = 1'b0;
  logic           all_0s = 1'b0;
  logic [AW-1:0]  n_tx_end = '0;
  logic [7:0]     tx_data;
  logic [AW-1:0]  tx_addr;
  logic           rx_we;
  logic [AW-1:0]  rx_addr;
  logic [7:0]     rx_data;
  logic [AW:0]    n_rx_cnt;
  logic           send_clr;
  logic           busy;
  logic [7:0]     mem [0:(1<<AW)-1];

  spi_master_fsm_if bus ();
  assign bus.miso = bus.mosi;
  assign tx_data  = mem[tx_addr];

  spi_master_fsm #(.N(N), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send),
    .cs_ctrl  (cs_ctrl),
    .all_1s   (all_1s),
    .all_0s   (all_0s),
    .n_tx_end (n_tx_end),
    .tx_data  (tx_data),
    .tx_addr  (tx_addr),
    .rx_we    (rx_we),
    .rx_addr  (rx_addr),
    .rx_data  (rx_data),
    .n_rx_cnt (n_rx_cnt),
    .send_clr (send_clr),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h, required nothing", name, act);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } rx_t;

  logic [7:0] exp_mosi [$];
  rx_t        exp_rx   [$];
  bit         cs_bad  = 0;
  int         rx_seen = 0;

  // Slave-side view: bytes assembled from mosi at sclk rising edges, RX writes retired in order
  initial begin
    logic       sclk_prev;
    logic [7:0] sh;
    int         nbits;
    rx_t        e;
    sclk_prev = 1'b0;
    sh        = '0;
    nbits     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sclk_prev = 1'b0;
        nbits     = 0;
      end else begin
        if (bus.sclk && !sclk_prev) begin
          sh = {sh[6:0], bus.mosi};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            if (exp_mosi.size() == 0) unexpected("mosi_extra_byte", 32'(sh));
            else chk("mosi_byte", 32'(sh), 32'(exp_mosi.pop_front()));
          end
        end
        if (rx_we) begin
          rx_seen++;
          if (exp_rx.size() == 0) unexpected("rx_we_extra", 32'(rx_addr));
          else begin
            e = exp_rx.pop_front();
            chk("rx_addr", 32'(rx_addr), 32'(e.a));
            chk("rx_data", 32'(rx_data), 32'(e.d));
          end
        end
        if (busy && bus.cs_n) cs_bad = 1;
        sclk_prev = bus.sclk;
      end
    end
  end

  // Reference: word i of a transfer carries the override pattern or mem[i]; loopback returns it
  task automatic push_exp(input int n, input bit a1, input bit a0);
    rx_t        e;
    logic [7:0] v;
    for (int i = 0; i <= n; i++) begin
      v   = a1 ? 8'hFF : (a0 ? 8'h00 : mem[i]);
      e.a = AW'(i);
      e.d = v;
      exp_mosi.push_back(v);
      exp_rx.push_back(e);
    end
  endtask

  task automatic xfer(input int n, input bit a1, input bit a0, input bit hold, input bit disturb);
    int t0;
    int t1;
    bit seen_clr;
    @(negedge clk);
    all_1s   = a1;
    all_0s   = a0;
    n_tx_end = AW'(n);
    push_exp(n, a1, a0);
    cs_bad = 0;
    send   = 1'b0;
    @(negedge clk);
    send = 1'b1;
    t0   = cyc;
    if (!hold) begin
      @(negedge clk);
      send = 1'b0;
    end
    if (disturb) begin
      repeat (12) @(negedge clk);
      n_tx_end = AW'($urandom);
      if (n == 0) begin
        all_1s = ~a1;
        all_0s = ~a0;
      end
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end
    seen_clr = 0;
    for (int b = 0; b < 20000 && !seen_clr; b++) begin
      if (send_clr) seen_clr = 1;
      else @(negedge clk);
    end
    t1 = cyc;
    chk("send_clr_seen", 32'(seen_clr), 32'd1);
    chk("latency", 32'(t1 - t0 + 1), 32'(1 + (n + 1) * FRAME_CYC + 1));
    chk("n_rx_cnt", 32'(n_rx_cnt), 32'(n + 1));
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("send_clr_width", 32'(send_clr), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("cs_n_held_low", 32'(cs_bad), 32'd0);
    chk("cs_n_idle", 32'(bus.cs_n), 32'd1);
    chk("mosi_queue_drained", 32'(exp_mosi.size()), 32'd0);
    chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    all_1s = 1'b0;
    all_0s = 1'b0;
  endtask

  initial begin
    int bcnt;
    int rx_before;
    bit seen;
    bit flag;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sclk", 32'(bus.sclk), 32'd0);
    chk("rst_mosi", 32'(bus.mosi), 32'd0);
    chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("rst_tx_addr", 32'(tx_addr), 32'd0);
    chk("rst_rx_we", 32'(rx_we), 32'd0);
    chk("rst_n_rx_cnt", 32'(n_rx_cnt), 32'd0);
    cs_ctrl = 1'b1;
    #1;
    chk("rst_cs_n_cs_ctrl", 32'(bus.cs_n), 32'd0);
    cs_ctrl = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // single frame, known pattern
    mem[0] = 8'hA5;
    xfer(0, 0, 0, 0, 0);

    // four frames
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    xfer(3, 0, 0, 0, 0);

    // overrides
    mem[0] = 8'h00; mem[1] = 8'h00;
    xfer(1, 1, 1, 0, 0);
    mem[0] = 8'hC3; mem[1] = 8'h3C;
    xfer(1, 0, 1, 0, 0);
    xfer(2, 1, 0, 0, 0);

    // send held high: one transfer only, then a fresh edge restarts
    xfer(1, 0, 0, 1, 0);
    bcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("held_send_no_restart", 32'(bcnt), 32'd0);
    xfer(0, 0, 0, 0, 0);

    // mid-transfer changes and a second send edge are ignored
    xfer(0, 1, 0, 0, 1);
    xfer(2, 0, 0, 0, 1);

    // full index range
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    xfer((1 << AW) - 1, 0, 0, 0, 0);

    // random transfers
    repeat (6) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      xfer(int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           0, ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of frame 1 of 3
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    n_tx_end = AW'(2);
    push_exp(2, 0, 0);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    seen = 0;
    for (int b = 0; b < 500 && !seen; b++) begin
      @(negedge clk);
      if (rx_we) seen = 1;
    end
    chk("reset_test_first_write", 32'(seen), 32'd1);
    repeat (12) @(negedge clk);
    chk("reset_test_in_shift", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_sclk", 32'(bus.sclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("midrst_n_rx_cnt", 32'(n_rx_cnt), 32'd0);
    chk("midrst_tx_addr", 32'(tx_addr), 32'd0);
    chk("midrst_mosi", 32'(bus.mosi), 32'd0);
    exp_mosi.delete();
    exp_rx.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_before = rx_seen;
    bcnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("no_start_after_rst", 32'(bcnt), 32'd0);
    chk("no_rx_after_rst", 32'(rx_seen - rx_before), 32'd0);

    // manual chip select while idle
    cs_ctrl = 1'b1;
    @(negedge clk);
    flag = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.cs_n !== 1'b0 || bus.sclk !== 1'b0 || busy) flag = 1;
    end
    chk("cs_ctrl_idle_hold", 32'(flag), 32'd0);
    chk("cs_ctrl_cs_n", 32'(bus.cs_n), 32'd0);
    cs_ctrl = 1'b0;
    #1;
    chk("cs_ctrl_release", 32'(bus.cs_n), 32'd1);

    // a transfer still works after the reset
    mem[0] = 8'h5A;
    xfer(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
